// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment capture monitor.
// Holds the active-low hex glyph table, the blank glyph and the FSM states.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs for hex digits 0..F, bit0=a ... bit6=g
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        BOTH = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-low seven-segment glyph back to hex.
// Ports: seg[6:0] in; hex[3:0], is_hex, is_blank out (purely combinational).
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       is_hex,
    output logic       is_blank
);

    always_comb begin
        hex    = 4'h0;
        is_hex = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                hex    = 4'(i);
                is_hex = 1'b1;
            end
        end
    end

    assign is_blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg_capture.sv
// seg_capture: recovers two hex digits from a multiplexed active-low
// segment/anode bus, with glyph settling, blank and error detection.
// Ports: clk, reset (sync, active-high), seg[6:0], an[1:0] in;
// digit0/digit1[3:0], blank[1:0], valid, upd, err, err_cnt[7:0] out.
// Build option: SEG_CAPTURE_ERRCNT_EN adds the saturating error counter;
// without it err_cnt is tied to zero.
module seg_capture
    import seg_pkg::*;
#(
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [1:0] an,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] blank,
    output logic       valid,
    output logic       upd,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [CNT_W-1:0] C_SAT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_ACC = CNT_W'(STABLE_CYCLES - 1);

    logic [8:0]       r_sample;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_digit0;
    logic [3:0]       r_digit1;
    logic [1:0]       r_blank;
    logic [1:0]       r_seen;
    logic             r_upd;
    logic             r_err;
    cap_state_t       r_state;
    cap_state_t       w_state_next;

    logic [8:0] w_in;
    logic       w_same;
    logic       w_accept;
    logic [3:0] w_hex;
    logic       w_is_hex;
    logic       w_is_blank;
    logic       w_onehot;
    logic       w_idx;
    logic       w_do_hex;
    logic       w_do_blank;
    logic       w_do_err;
    logic [3:0] w_cur_digit;
    logic       w_cur_blank;
    logic       w_chg_hex;
    logic       w_chg_blank;

    assign w_in   = {an, seg};
    assign w_same = (w_in == r_sample);
    // Counter saturates at C_SAT, so this fires once per held glyph
    assign w_accept = w_same && (r_cnt == C_ACC);

    seg_pattern_decode u_dec (
        .seg      (seg),
        .hex      (w_hex),
        .is_hex   (w_is_hex),
        .is_blank (w_is_blank)
    );

    // an is active-low: 2'b10 drives digit0, 2'b01 drives digit1
    assign w_onehot = (an == 2'b10) || (an == 2'b01);
    assign w_idx    = an[0];

    assign w_do_hex   = w_accept && w_onehot && w_is_hex;
    assign w_do_blank = w_accept && w_onehot && w_is_blank;
    assign w_do_err   = w_accept &&
                        ((an == 2'b00) ||
                         (w_onehot && !w_is_hex && !w_is_blank));

    assign w_cur_digit = w_idx ? r_digit1 : r_digit0;
    assign w_cur_blank = r_blank[w_idx];

    assign w_chg_hex   = w_do_hex &&
                         ((w_cur_digit != w_hex) || w_cur_blank);
    assign w_chg_blank = w_do_blank && !w_cur_blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= 9'h000;
            r_cnt    <= '0;
        end else begin
            r_sample <= w_in;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != C_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit0 <= 4'h0;
            r_digit1 <= 4'h0;
            r_blank  <= 2'b00;
            r_seen   <= 2'b00;
            r_upd    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_upd <= w_chg_hex || w_chg_blank;
            r_err <= w_do_err;
            if (w_do_hex) begin
                if (w_idx) begin
                    r_digit1 <= w_hex;
                end else begin
                    r_digit0 <= w_hex;
                end
                r_blank[w_idx] <= 1'b0;
                r_seen[w_idx]  <= 1'b1;
            end else if (w_do_blank) begin
                r_blank[w_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_do_hex) begin
                    w_state_next = ONE;
                end
            end
            ONE: begin
                if (w_do_hex && !r_seen[w_idx]) begin
                    w_state_next = BOTH;
                end
            end
            BOTH: begin
                w_state_next = BOTH;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= 8'h00;
        end else if (w_do_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    assign digit0 = r_digit0;
    assign digit1 = r_digit1;
    assign blank  = r_blank;
    assign valid  = (r_state == BOTH);
    assign upd    = r_upd;
    assign err    = r_err;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: scoreboard bench for seg_capture with a run-length
// reference model; directed scenarios followed by randomized glyph holds.
module tb_seg_capture;

    localparam int STABLE = 4;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk;
    logic       reset;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [1:0] blank;
    logic       valid;
    logic       upd;
    logic       err;
    logic [7:0] err_cnt;

    seg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .reset   (reset),
        .seg     (seg),
        .an      (an),
        .digit0  (digit0),
        .digit1  (digit1),
        .blank   (blank),
        .valid   (valid),
        .upd     (upd),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         c;
        bit         is_err;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [1:0] bl;
        bit         vld;
        logic [7:0] ec;
    } ev_t;

    ev_t q[$];

    // Reference model: acceptance is "the same bus value seen on
    // STABLE+1 consecutive edges"
    logic [8:0] m_last;
    int         m_run;
    logic [3:0] m_d [2];
    logic [1:0] m_bl;
    logic [1:0] m_seen;
    int         m_ec;
    bit         m_upd;
    bit         m_err;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_d[0] = 0; m_d[1] = 0;
        m_bl = 0; m_seen = 0; m_ec = 0;
        m_last = 0; m_run = 1;
        m_upd = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic r, input logic [8:0] v);
        logic [1:0] a;
        logic [6:0] s;
        int idx;
        int hv;
        ev_t e;
        if (r) begin
            model_reset();
            return;
        end
        m_upd = 0;
        m_err = 0;
        if (v == m_last) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_last = v;
            m_run  = 1;
        end
        if (m_run == STABLE + 1) begin
            a = v[8:7];
            s = v[6:0];
            if (a == 2'b00) begin
                m_err = 1;
            end else if (a != 2'b11) begin
                idx = (a == 2'b01) ? 1 : 0;
                hv = -1;
                for (int i = 0; i < 16; i++)
                    if (s == HEX[i]) hv = i;
                if (hv >= 0) begin
                    if (m_d[idx] != 4'(hv) || m_bl[idx]) m_upd = 1;
                    m_d[idx]    = 4'(hv);
                    m_bl[idx]   = 0;
                    m_seen[idx] = 1;
                end else if (s == 7'h7F) begin
                    if (!m_bl[idx]) m_upd = 1;
                    m_bl[idx] = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
`ifdef SEG_CAPTURE_ERRCNT_EN
        if (m_err && m_ec < 255) m_ec++;
`endif
        if (m_upd || m_err) begin
            e.c      = cyc + 1;
            e.is_err = m_err;
            e.d0     = m_d[0];
            e.d1     = m_d[1];
            e.bl     = m_bl;
            e.vld    = m_seen[0] && m_seen[1];
            e.ec     = 8'(m_ec);
            q.push_back(e);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] a,
                        input logic [6:0] s);
        reset = r;
        an    = a;
        seg   = s;
        model_edge(r, {a, s});
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [1:0] a, input logic [6:0] s,
                        input int n);
        for (int i = 0; i < n; i++) step(1'b0, a, s);
    endtask

    task automatic check_state(input string nm);
        chk({nm, ".digit0"}, int'(digit0), int'(m_d[0]));
        chk({nm, ".digit1"}, int'(digit1), int'(m_d[1]));
        chk({nm, ".blank"}, int'(blank), int'(m_bl));
        chk({nm, ".valid"}, int'(valid), int'(m_seen[0] && m_seen[1]));
        chk({nm, ".upd"}, int'(upd), int'(m_upd));
        chk({nm, ".err"}, int'(err), int'(m_err));
        chk({nm, ".err_cnt"}, int'(err_cnt), m_ec);
    endtask

    // Monitor: every DUT pulse must match the next expected event
    always @(negedge clk) begin
        ev_t e;
        if (upd || err) begin
            chk("excl", int'(upd && err), 0);
            if (q.size() == 0) begin
                chk("unexpected_event", cyc, -1);
            end else begin
                e = q.pop_front();
                chk("ev.cycle", cyc, e.c);
                chk("ev.err", int'(err), int'(e.is_err));
                chk("ev.d0", int'(digit0), int'(e.d0));
                chk("ev.d1", int'(digit1), int'(e.d1));
                chk("ev.blank", int'(blank), int'(e.bl));
                chk("ev.valid", int'(valid), int'(e.vld));
                chk("ev.errcnt", int'(err_cnt), int'(e.ec));
            end
        end else if (q.size() != 0 && q[0].c < cyc) begin
            chk("missed_event", cyc, q[0].c);
            void'(q.pop_front());
        end
    end

    initial begin
        logic [1:0] a;
        logic [6:0] s;
        int k;
        reset = 1'b1;
        an    = 2'b11;
        seg   = 7'h7F;
        model_reset();
        step(1'b1, 2'b11, 7'h7F);
        step(1'b1, 2'b11, 7'h7F);
        check_state("reset");

        hold(2'b10, 7'h24, 6);
        check_state("d0_two");
        chk("d0_two.lit", int'(digit0), 2);

        hold(2'b01, 7'h0E, 6);
        hold(2'b01, 7'h0E, 6);
        check_state("d1_f");
        chk("d1_f.valid_lit", int'(valid), 1);

        for (int i = 0; i < 20; i++)
            step(1'b0, 2'b10, (i % 2) ? 7'h30 : 7'h79);
        check_state("toggle");

        hold(2'b10, 7'h7E, 6);
        check_state("illegal");
`ifdef SEG_CAPTURE_ERRCNT_EN
        chk("illegal.cnt_lit", int'(err_cnt), 1);
`else
        chk("illegal.cnt_lit", int'(err_cnt), 0);
`endif

        hold(2'b00, 7'h40, 6);
        hold(2'b10, 7'h7F, 6);
        check_state("blank0");
        chk("blank0.lit", int'(blank[0]), 1);

        hold(2'b01, 7'h00, 2);
        step(1'b1, 2'b01, 7'h00);
        check_state("mid_reset");
        hold(2'b01, 7'h00, 4);
        chk("post_reset.d1_early", int'(digit1), 0);
        step(1'b0, 2'b01, 7'h00);
        chk("post_reset.d1", int'(digit1), 8);
        check_state("post_reset");

        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 9);
            a = (k < 4) ? 2'b10 : (k < 8) ? 2'b01 :
                (k < 9) ? 2'b11 : 2'b00;
            k = $urandom_range(0, 19);
            if (k < 12) s = HEX[$urandom_range(0, 15)];
            else if (k < 15) s = 7'h7F;
            else s = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 59) == 0) step(1'b1, a, s);
            hold(a, s, $urandom_range(1, 7));
        end
        hold(2'b11, 7'h7F, 8);
        check_state("random_end");
        @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
